// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic unit.
//   WIDTH_18   : default operand/result width
//   SLICE_2    : bits handled per clock by the serial datapaths
//   NUM_SLICES : number of slices that make up one full operand
//   state_t    : control FSM states of the serial subtractor
package arith_pkg;

  localparam int unsigned WIDTH_18   = 18;
  localparam int unsigned SLICE_2    = 2;
  localparam int unsigned NUM_SLICES = WIDTH_18 / SLICE_2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_slice.sv
// Combinational 2-bit subtract slice, built as an adder slice with the
// subtrahend and the carry inverted.
//   a, b       : minuend / subtrahend slice
//   borrowIn   : borrow from the less significant slice
//   diff       : slice difference
//   borrowOut  : borrow into the next slice
module subtractor_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       borrowIn,
  output logic [1:0] diff,
  output logic       borrowOut
);

  logic [2:0] sum;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, ~b} + {2'b00, ~borrowIn};
    diff      = sum[1:0];
    borrowOut = ~sum[2];
  end

endmodule

// File: rtl/bit18_serial_subtractor.sv
// Sequential unsigned subtractor: difference = operand1 - operand2,
// processed SLICE bits per clock, least significant slice first.
//   clk, rstN            : clock, asynchronous active-low reset
//   start                : request, accepted only while idle
//   operand1, operand2   : minuend / subtrahend, captured on accept
//   busy                 : high while slices are being processed
//   done                 : one-cycle pulse when the outputs update
//   difference           : (operand1 - operand2) mod 2^WIDTH
//   borrowOut            : unsigned underflow (operand1 < operand2)
//   zero                 : difference == 0
module bit18_serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_18,
  parameter int unsigned SLICE = SLICE_2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrowOut,
  output logic             zero
);

  localparam int unsigned NUM  = WIDTH / SLICE;
  localparam logic [3:0]  LAST = 4'(NUM - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_next;
  logic             borrow_q;
  logic [SLICE-1:0] s_diff;
  logic             s_bout;
  logic             last;

  subtractor_slice u_slice (
    .a         (opa_q[SLICE-1:0]),
    .b         (opb_q[SLICE-1:0]),
    .borrowIn  (borrow_q),
    .diff      (s_diff),
    .borrowOut (s_bout)
  );

  assign last     = (cnt_q == LAST);
  // Result fills from the top, so after the final slice it is fully aligned.
  assign res_next = {s_diff, res_q[WIDTH-1:SLICE]};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      difference <= '0;
      borrowOut  <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q    <= operand1;
            opb_q    <= operand2;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          opa_q    <= {{SLICE{1'b0}}, opa_q[WIDTH-1:SLICE]};
          opb_q    <= {{SLICE{1'b0}}, opb_q[WIDTH-1:SLICE]};
          res_q    <= res_next;
          borrow_q <= s_bout;
          cnt_q    <= cnt_q + 4'd1;
          if (last) begin
            difference <= res_next;
            borrowOut  <= s_bout;
            zero       <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
